// File: rtl/freq_gen_pkg.sv
// Shared cymometer constants: reference clock, word width, generator FSM encoding.
package freq_gen_pkg;

    localparam logic [25:0] CLK_FS_DEF = 26'd50000000;
    localparam int          DATA_W_DEF = 20;
    localparam int          ACC_W      = 27;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } fg_state_t;

endpackage

// File: rtl/freq_acc.sv
// Phase accumulator modulo CLK_FS; o_toggle flags each wrap of an enabled cycle.
module freq_acc
    import freq_gen_pkg::*;
#(
    parameter logic [25:0] CLK_FS = CLK_FS_DEF,
    parameter int          STEP_W = DATA_W_DEF + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [STEP_W-1:0] i_step,
    input  logic              i_enable,
    input  logic              i_clear,
    output logic              o_toggle
);

    localparam logic [ACC_W-1:0] LIMIT = ACC_W'(CLK_FS);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_sum;
    logic             w_wrap;

    assign w_sum    = r_acc + ACC_W'(i_step);
    assign w_wrap   = (w_sum >= LIMIT);
    // Toggle is independent of clear so the owner can apply a change on the wrap cycle.
    assign o_toggle = i_enable & w_wrap;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_enable) begin
            r_acc <= w_wrap ? (w_sum - LIMIT) : w_sum;
        end
    end

endmodule

// File: rtl/freq_gen.sv
// Programmable square-wave generator with clamped, glitch-free frequency changes.
module freq_gen
    import freq_gen_pkg::*;
#(
    parameter logic [25:0] CLK_FS = CLK_FS_DEF,
    parameter int          DATA_W = DATA_W_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] freq_set,
    input  logic              set_valid,
    output logic              set_ready,
    output logic              clk_out,
    output logic [DATA_W-1:0] freq_cur,
    output logic              running
);

    localparam int          STEP_W = DATA_W + 1;
    localparam logic [31:0] HALF   = 32'(CLK_FS) >> 1;

    fg_state_t         r_state;
    fg_state_t         w_state_nxt;
    logic [DATA_W-1:0] r_cur;
    logic [DATA_W-1:0] w_cur_nxt;
    logic [DATA_W-1:0] r_pend;
    logic [DATA_W-1:0] w_pend_nxt;
    logic              r_ready;
    logic              w_ready_nxt;
    logic              r_clk;

    logic [31:0]       w_set_ext;
    logic [DATA_W-1:0] w_clamped;
    logic              w_accept;
    logic [STEP_W-1:0] w_step;
    logic              w_acc_en;
    logic              w_acc_clr;
    logic              w_toggle;

    assign w_set_ext = 32'(freq_set);
    assign w_clamped = (w_set_ext > HALF) ? DATA_W'(HALF) : freq_set;
    assign w_accept  = set_valid & r_ready;
    assign w_step    = {r_cur, 1'b0};

    freq_acc #(
        .CLK_FS (CLK_FS),
        .STEP_W (STEP_W)
    ) u_acc (
        .i_clk    (sys_clk),
        .i_rst_n  (sys_rst_n),
        .i_step   (w_step),
        .i_enable (w_acc_en),
        .i_clear  (w_acc_clr),
        .o_toggle (w_toggle)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_pend_nxt  = r_pend;
        w_ready_nxt = 1'b1;
        w_acc_en    = 1'b0;
        w_acc_clr   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_cur_nxt = w_clamped;
                    if (w_clamped != '0) begin
                        w_state_nxt = ST_RUN;
                        w_acc_clr   = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                w_acc_en = 1'b1;
                if (w_accept) begin
                    w_pend_nxt  = w_clamped;
                    w_state_nxt = ST_PEND;
                    w_ready_nxt = 1'b0;
                end
            end
            ST_PEND: begin
                w_acc_en    = 1'b1;
                w_ready_nxt = 1'b0;
                // Swap only on the falling toggle so a high phase is never cut short.
                if ((w_toggle && r_clk) || (!r_clk && w_step == '0)) begin
                    w_cur_nxt   = r_pend;
                    w_pend_nxt  = '0;
                    w_acc_clr   = 1'b1;
                    w_ready_nxt = 1'b1;
                    w_state_nxt = (r_pend != '0) ? ST_RUN : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
            r_cur   <= '0;
            r_pend  <= '0;
            r_ready <= 1'b0;
            r_clk   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            r_pend  <= w_pend_nxt;
            r_ready <= w_ready_nxt;
            r_clk   <= r_clk ^ w_toggle;
        end
    end

    assign set_ready = r_ready;
    assign clk_out   = r_clk;
    assign freq_cur  = r_cur;
    assign running   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_freq_gen.sv
// Directed and randomized checks of freq_gen against a closed-form toggle model.
module tb_freq_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        d_rst_n, d_valid, d_ready, d_clk, d_run;
    logic [19:0] d_set, d_cur;
    logic        s_rst_n, s_valid, s_ready, s_clk, s_run;
    logic [19:0] s_set, s_cur;
    logic        w_rst_n, w_valid, w_ready, w_clk, w_run;
    logic [25:0] w_set, w_cur;

    freq_gen u_def (
        .sys_clk   (clk),
        .sys_rst_n (d_rst_n),
        .freq_set  (d_set),
        .set_valid (d_valid),
        .set_ready (d_ready),
        .clk_out   (d_clk),
        .freq_cur  (d_cur),
        .running   (d_run)
    );

    freq_gen #(.CLK_FS(26'd1000)) u_sm (
        .sys_clk   (clk),
        .sys_rst_n (s_rst_n),
        .freq_set  (s_set),
        .set_valid (s_valid),
        .set_ready (s_ready),
        .clk_out   (s_clk),
        .freq_cur  (s_cur),
        .running   (s_run)
    );

    freq_gen #(.DATA_W(26)) u_wd (
        .sys_clk   (clk),
        .sys_rst_n (w_rst_n),
        .freq_set  (w_set),
        .set_valid (w_valid),
        .set_ready (w_ready),
        .clk_out   (w_clk),
        .freq_cur  (w_cur),
        .running   (w_run)
    );

    int     n_vec = 0;
    int     n_err = 0;
    longint k     = 0;

    // Output level after k accumulate cycles: parity of the number of wraps.
    function automatic logic [63:0] mdl_clk(longint kk, longint stp, longint fs);
        return 64'(((kk * stp) / fs) % 2);
    endfunction

    function automatic logic [63:0] o_clk(int u);
        case (u)
            0:       return 64'(d_clk);
            1:       return 64'(s_clk);
            default: return 64'(w_clk);
        endcase
    endfunction

    function automatic logic [63:0] o_run(int u);
        case (u)
            0:       return 64'(d_run);
            1:       return 64'(s_run);
            default: return 64'(w_run);
        endcase
    endfunction

    function automatic logic [63:0] o_rdy(int u);
        case (u)
            0:       return 64'(d_ready);
            1:       return 64'(s_ready);
            default: return 64'(w_ready);
        endcase
    endfunction

    function automatic logic [63:0] o_cur(int u);
        case (u)
            0:       return 64'(d_cur);
            1:       return 64'(s_cur);
            default: return 64'(w_cur);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s k=%0d: observed %0d expected %0d", tag, k, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        k++;
    endtask

    task automatic drive(input int u, input logic v, input logic [63:0] f);
        case (u)
            0: begin d_valid = v; d_set = f[19:0]; end
            1: begin s_valid = v; s_set = f[19:0]; end
            default: begin w_valid = v; w_set = f[25:0]; end
        endcase
    endtask

    task automatic accept(input int u, input logic [63:0] f);
        chk("ready_before_accept", o_rdy(u), 64'd1);
        drive(u, 1'b1, f);
        cyc();
        drive(u, 1'b0, 64'd0);
    endtask

    task automatic set_rst(input int u, input logic v);
        case (u)
            0:       d_rst_n = v;
            1:       s_rst_n = v;
            default: w_rst_n = v;
        endcase
    endtask

    task automatic do_rst(input int u);
        set_rst(u, 1'b0);
        cyc();
        chk("rst_clk", o_clk(u), 64'd0);
        chk("rst_run", o_run(u), 64'd0);
        chk("rst_ready", o_rdy(u), 64'd0);
        chk("rst_cur", o_cur(u), 64'd0);
        set_rst(u, 1'b1);
        cyc();
        chk("ready_after_rst", o_rdy(u), 64'd1);
    endtask

    task automatic run_mdl(input int u, input int n, input longint stp,
                           input longint fs, input string tag);
        for (int i = 0; i < n; i++) begin
            cyc();
            chk(tag, o_clk(u), mdl_clk(k, stp, fs));
            chk({tag, "_run"}, o_run(u), 64'(stp != 0));
        end
    endtask

    initial begin
        bit     tg [0:2100];
        int     first;
        int     cnt;
        int     st [4];
        logic   prev;
        longint f;
        longint ec;
        longint last_rise;
        int     n_rise;

        d_rst_n = 1'b0; d_valid = 1'b0; d_set = '0;
        s_rst_n = 1'b0; s_valid = 1'b0; s_set = '0;
        w_rst_n = 1'b0; w_valid = 1'b0; w_set = '0;
        for (int u = 0; u < 3; u++) do_rst(u);

        // 500 kHz at 50 MHz: 50 high / 50 low
        accept(0, 64'd500000);
        k = 0;
        chk("r030_cur", o_cur(0), 64'd500000);
        chk("r030_run", o_run(0), 64'd1);
        run_mdl(0, 250, 1000000, 50000000, "r030_clk");

        // Stop request during a high phase
        chk("r034_high", o_clk(0), 64'd1);
        accept(0, 64'd0);
        chk("r034_ready_pend", o_rdy(0), 64'd0);
        while (k < 300) begin
            chk("r034_clk", o_clk(0), mdl_clk(k, 1000000, 50000000));
            chk("r034_run", o_run(0), 64'd1);
            cyc();
        end
        chk("r034_fall", o_clk(0), 64'd0);
        chk("r034_idle", o_run(0), 64'd0);
        chk("r034_cur", o_cur(0), 64'd0);
        chk("r034_ready", o_rdy(0), 64'd1);
        for (int i = 0; i < 60; i++) begin
            cyc();
            chk("r034_low", o_clk(0), 64'd0);
        end

        // Reset while a change is pending
        accept(0, 64'd500000);
        k = 0;
        run_mdl(0, 60, 1000000, 50000000, "r035_pre");
        accept(0, 64'd123);
        chk("r035_pend", o_rdy(0), 64'd0);
        chk("r035_high", o_clk(0), 64'd1);
        do_rst(0);
        for (int i = 0; i < 150; i++) begin
            cyc();
            chk("r035_clk", o_clk(0), 64'd0);
            chk("r035_cur", o_cur(0), 64'd0);
        end

        // 3 Hz at CLK_FS=1000
        accept(1, 64'd3);
        k = 0;
        first = -1;
        prev  = 1'b0;
        for (int i = 1; i <= 2100; i++) begin
            cyc();
            chk("r031_clk", o_clk(1), mdl_clk(k, 6, 1000));
            tg[i] = (s_clk != prev);
            prev  = s_clk;
            if (first < 0 && s_clk) first = i;
        end
        chk("r031_first", 64'(first), 64'd167);
        st = '{1, 250, 833, 1101};
        foreach (st[j]) begin
            cnt = 0;
            for (int i = st[j]; i < st[j] + 1000; i++) cnt += int'(tg[i]);
            chk("r031_window", 64'(cnt), 64'd6);
        end

        // Clamp at CLK_FS=1000
        do_rst(1);
        accept(1, 64'd700);
        k = 0;
        chk("clamp_cur", o_cur(1), 64'd500);
        run_mdl(1, 20, 1000, 1000, "clamp_clk");

        // Random frequencies
        for (int it = 0; it < 8; it++) begin
            do_rst(1);
            f  = longint'($urandom_range(0, 600));
            ec = (f > 500) ? 500 : f;
            accept(1, 64'(f));
            k = 0;
            chk("rnd_cur", o_cur(1), 64'(ec));
            run_mdl(1, 300, 2 * ec, 1000, "rnd_clk");
        end

        // 30 MHz request clamps to 25 MHz
        accept(2, 64'd30000000);
        k = 0;
        chk("r032_cur", o_cur(2), 64'd25000000);
        run_mdl(2, 20, 50000000, 50000000, "r032_clk");

        // 1 MHz -> 2 MHz change requested mid-high
        do_rst(2);
        accept(2, 64'd1000000);
        k = 0;
        run_mdl(2, 30, 2000000, 50000000, "r033_old");
        accept(2, 64'd2000000);
        chk("r033_pend", o_rdy(2), 64'd0);
        drive(2, 1'b1, 64'd3000000);
        while (k < 50) begin
            if (k == 36) drive(2, 1'b0, 64'd0);
            chk("r033_hold", o_clk(2), mdl_clk(k, 2000000, 50000000));
            chk("r033_busy", o_rdy(2), 64'd0);
            cyc();
        end
        chk("r033_fall", o_clk(2), 64'd0);
        chk("r033_ready", o_rdy(2), 64'd1);
        chk("r033_cur", o_cur(2), 64'd2000000);
        k         = 0;
        prev      = 1'b0;
        last_rise = -1;
        n_rise    = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            chk("r033_new", o_clk(2), mdl_clk(k, 4000000, 50000000));
            if (w_clk && !prev) begin
                if (last_rise >= 0) chk("r033_period", 64'(k - last_rise), 64'd25);
                last_rise = k;
                n_rise++;
            end
            prev = w_clk;
        end
        chk("r033_rises", 64'(n_rise), 64'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/freq_gen.md
FREQ_GEN -- requirements
Module: freq_gen

Interface
REQ-001 Parameter CLK_FS, default 26'd50000000, reference clock frequency in Hz.
REQ-002 Parameter DATA_W, default 20, width of the frequency word in Hz; matches the cymometer result width.
REQ-003 sys_clk  input  1  single clock; all logic on rising edge.
REQ-004 sys_rst_n  input  1  reset, synchronous, active-low.
REQ-005 freq_set  input  DATA_W  requested output frequency in Hz.
REQ-006 set_valid  input  1  freq_set is valid this cycle.
REQ-007 set_ready  output  1  block can accept a new freq_set.
REQ-008 clk_out  output  1  generated square wave, registered.
REQ-009 freq_cur  output  DATA_W  frequency currently in effect, after clamping.
REQ-010 running  output  1  high while clk_out is toggling.

Function
REQ-011 A transfer occurs on a cycle where set_valid and set_ready are both high; no other cycle changes the target.
REQ-012 An accepted value above CLK_FS/2 is clamped to CLK_FS/2; freq_cur reports the clamped value.
REQ-013 Step = 2*freq_cur, held in 21 bits; the accumulator is 27 bits and always below CLK_FS after update.
REQ-014 Every RUN cycle: sum = acc + step; if sum >= CLK_FS then acc <= sum - CLK_FS and clk_out toggles, else acc <= sum.
REQ-015 Long-run clk_out frequency equals freq_cur exactly, as an average over CLK_FS cycles; per-period jitter is at most 1 sys_clk.
REQ-016 The FSM has three states: IDLE, RUN and PEND.
REQ-017 IDLE: clk_out=0, running=0, set_ready=1; accepting f>0 enters RUN next cycle with acc=0 and clk_out=0; accepting f=0 stays in IDLE and sets freq_cur=0.
REQ-018 RUN: set_ready=1, running=1; an accept latches the new value into a pending register and enters PEND.
REQ-019 PEND: set_ready=0; accumulation continues with the old step until the cycle on which clk_out toggles 1->0.
REQ-020 On that 1->0 toggle cycle in PEND, the block applies the pending value: acc <= 0 and freq_cur updates; it enters RUN, or IDLE if the pending value is 0.
REQ-021 If clk_out is already 0 and step is 0 on PEND entry, the pending value is applied on the next cycle; no high pulse is ever truncated (glitch-free change).
REQ-022 Latency from an accept in IDLE to the first clk_out rise is ceil(CLK_FS/step) cycles after RUN entry.
REQ-023 When freq_cur=CLK_FS/2, clk_out toggles every cycle.
REQ-024 set_valid while set_ready=0 is ignored; the source must hold it.

Reset
REQ-025 While sys_rst_n=0 at a clock edge: state=IDLE, acc=0, pending=0, freq_cur=0, clk_out=0, running=0, set_ready=0.
REQ-026 set_ready shall rise on the first cycle after reset release.
REQ-027 Reset mid-period or in PEND discards the pending value and drives clk_out low on the same edge.

Structure
REQ-028 CLK_FS default, DATA_W and the FSM state encodings (IDLE/RUN/PEND) shall live in the shared cymometer constants package.
REQ-029 One sub-module, freq_acc, shall implement the accumulator and toggle (inputs step, enable, clear; output toggle pulse); freq_gen owns the FSM, handshake and clamping.

Verification
REQ-030 CLK_FS=50000000, accept 500000 from IDLE -> clk_out period exactly 100 cycles, 50 high / 50 low, freq_cur=500000.
REQ-031 CLK_FS=1000 override, accept 3 -> first toggle 167 cycles after RUN entry; exactly 6 toggles in every 1000-cycle window.
REQ-032 Accept 30000000 with CLK_FS=50000000 -> freq_cur=25000000 and clk_out toggles every cycle.
REQ-033 While running at 1 MHz, accept 2 MHz mid-high-phase -> set_ready=0 until the next fall, no high pulse shorter than 25 cycles, then a 25-cycle period.
REQ-034 Accept 0 while running -> clk_out finishes its high phase, then stays 0; running=0; state IDLE.
REQ-035 Assert sys_rst_n=0 for 1 cycle in PEND -> all outputs match REQ-025 on that edge; set_ready=1 on the next cycle; the pending value is never applied.
